// File: rtl/any1_pkg.sv
// rtl/any1_pkg.sv - shared aligned-instruction record and queue constants
package any1_pkg;

   // Default instruction queue depth (power of two, at least 2)
   localparam int IQ_DEPTH = 4;

   // Opcode byte the aligner drops into ir when an instruction address faults
   localparam logic [7:0] FLT_IADR = 8'hF3;

   // Aligned instruction as produced by the aligner
   typedef struct packed {
      logic        v;
      logic        predict_taken;
      logic [63:0] ir;
      logic [31:0] ip;
      logic [31:0] pip;
   } sInstAlignOut;

endpackage

// File: rtl/any1_iqueue_mem.sv
// rtl/any1_iqueue_mem.sv - queue storage, one sync write port, one async read port
module any1_iqueue_mem
   import any1_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  sInstAlignOut  wd,
   input  logic [AW-1:0] ra,
   output sInstAlignOut  rd
);

   sInstAlignOut mem [DEPTH];

   // Write port: contents carry no reset, the control logic never reads stale slots
   always_ff @(posedge clk) begin
      if (we)
         mem[wa] <= wd;
   end

   assign rd = mem[ra];

endmodule

// File: rtl/any1_iqueue.sv
// rtl/any1_iqueue.sv - instruction queue between aligner and decode
module any1_iqueue
   import any1_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          rst_i,
   input  logic          clk_i,
   input  logic          flush_i,
   input  sInstAlignOut  i,
   output logic          rdy_o,
   input  logic          pop_i,
   output sInstAlignOut  o,
   output logic [AW:0]   count_o,
   output logic          full_o,
   output logic          empty_o
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push;
   logic          pop;
   sInstAlignOut  head;

   assign full_o  = (count == DEPTH_C);
   assign empty_o = (count == '0);
   assign count_o = count;

   // A pop frees the slot this cycle, so a full queue still takes a push alongside it
   assign rdy_o = !full_o | pop_i;
   assign push  = i.v & rdy_o & !flush_i;
   assign pop   = pop_i & !empty_o & !flush_i;

   any1_iqueue_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk (clk_i),
      .we  (push),
      .wa  (wr_ptr),
      .wd  (i),
      .ra  (rd_ptr),
      .rd  (head)
   );

   // Head is zeroed while empty so decode never sees stale fields
   always_comb begin
      o = '0;
      if (!empty_o)
         o = head;
   end

   // Pointer and occupancy tracking; flush drops everything including this cycle's traffic
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

   // Overflow guard: a push into a full queue must always be paired with a pop
   always @(posedge clk_i) begin
      if (!rst_i)
         assert (!(push && full_o && !pop));
   end

endmodule

// File: tb/tb_any1_iqueue.sv
// tb/tb_any1_iqueue.sv - self-checking bench for any1_iqueue
module tb_any1_iqueue;
   import any1_pkg::*;

   localparam int DEPTH = IQ_DEPTH;

   logic         rst_i;
   logic         clk_i;
   logic         flush_i;
   sInstAlignOut i;
   logic         rdy_o;
   logic         pop_i;
   sInstAlignOut o;
   logic [2:0]   count_o;
   logic         full_o;
   logic         empty_o;

   int n_cmp = 0;
   int n_err = 0;

   sInstAlignOut q[$];
   logic         last_push;

   any1_iqueue #(.DEPTH(DEPTH)) dut (
      .rst_i   (rst_i),
      .clk_i   (clk_i),
      .flush_i (flush_i),
      .i       (i),
      .rdy_o   (rdy_o),
      .pop_i   (pop_i),
      .o       (o),
      .count_o (count_o),
      .full_o  (full_o),
      .empty_o (empty_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic sInstAlignOut mk(input logic [31:0] ip, input logic [63:0] ir, input logic pt);
      sInstAlignOut r;
      r.v = 1'b1;
      r.predict_taken = pt;
      r.ir = ir;
      r.ip = ip;
      r.pip = ip + 32'd4;
      return r;
   endfunction

   task automatic check_outputs();
      sInstAlignOut exp_o;
      int n;
      n = q.size();
      exp_o = (n > 0) ? q[0] : '0;
      chk("count", 160'(count_o), 160'(n));
      chk("empty", 160'(empty_o), 160'(n == 0));
      chk("full", 160'(full_o), 160'(n == DEPTH));
      chk("rdy", 160'(rdy_o), 160'((n < DEPTH) || pop_i));
      chk("head", 160'(o), 160'(exp_o));
   endtask

   // Check at negedge, then let one clock edge pass and apply the reference rules
   task automatic step();
      logic rdy_m, push_m, pop_m;
      @(negedge clk_i);
      check_outputs();
      rdy_m  = (q.size() < DEPTH) || pop_i;
      push_m = i.v && rdy_m && !flush_i;
      pop_m  = pop_i && (q.size() > 0) && !flush_i;
      @(posedge clk_i);
      if (flush_i)
         q.delete();
      else begin
         if (pop_m)
            void'(q.pop_front());
         if (push_m)
            q.push_back(i);
      end
      last_push = push_m;
      #1;
   endtask

   task automatic idle();
      i = '0;
      pop_i = 1'b0;
      flush_i = 1'b0;
   endtask

   initial begin
      logic [63:0] fir;
      rst_i = 1'b1;
      last_push = 1'b0;
      idle();
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_count", 160'(count_o), 160'(0));
      chk("rst_empty", 160'(empty_o), 160'(1));
      chk("rst_full", 160'(full_o), 160'(0));
      chk("rst_rdy", 160'(rdy_o), 160'(1));
      chk("rst_o", 160'(o), 160'(0));
      rst_i = 1'b0;

      // Three back-to-back pushes, head visible one cycle after the first
      i = mk(32'h100, 64'h11, 1'b0); step();
      chk("lat_ip", 160'(o.ip), 160'(32'h100));
      i = mk(32'h104, 64'h12, 1'b0); step();
      i = mk(32'h108, 64'h13, 1'b0); step();
      idle(); step();
      chk("three_count", 160'(count_o), 160'(3));
      chk("three_empty", 160'(empty_o), 160'(0));

      // Drain, then fill to DEPTH and hold a fifth push against backpressure
      pop_i = 1'b1; repeat (3) step();
      idle();
      for (int k = 0; k < DEPTH; k++) begin
         i = mk(32'h200 + 32'(4*k), 64'(k), 1'b0); step();
      end
      i = mk(32'h210, 64'h99, 1'b0);
      repeat (2) step();
      chk("full_flag", 160'(full_o), 160'(1));
      chk("full_rdy", 160'(rdy_o), 160'(0));
      chk("full_count", 160'(count_o), 160'(4));
      pop_i = 1'b1; step();
      idle();
      chk("fullpp_count", 160'(count_o), 160'(4));
      chk("fullpp_ip", 160'(o.ip), 160'(32'h204));
      pop_i = 1'b1; repeat (4) step();
      chk("drained", 160'(empty_o), 160'(1));

      // Continuous push/pop across pointer wrap
      idle();
      i = mk(32'h300, 64'h0, 1'b0); step();
      for (int k = 1; k <= 10; k++) begin
         i = mk(32'h300 + 32'(4*k), 64'(k), 1'b0);
         pop_i = 1'b1;
         step();
         chk("wrap_ip", 160'(o.ip), 160'(32'h300 + 32'(4*k)));
      end
      idle(); pop_i = 1'b1; step();
      idle();

      // Flush with a concurrent push and pop
      for (int k = 0; k < 3; k++) begin
         i = mk(32'h380 + 32'(4*k), 64'(k), 1'b0); step();
      end
      i = mk(32'h400, 64'h44, 1'b0); pop_i = 1'b1; flush_i = 1'b1; step();
      idle();
      chk("flush_count", 160'(count_o), 160'(0));
      chk("flush_v", 160'(o.v), 160'(0));
      step();

      // Faulted instruction passes through unchanged
      fir = {40'h0, FLT_IADR, 16'h0};
      i = mk(32'h502, fir, 1'b1); step();
      idle();
      chk("flt_ir", 160'(o.ir), 160'(fir));
      chk("flt_pt", 160'(o.predict_taken), 160'(1));
      chk("flt_ip", 160'(o.ip), 160'(32'h502));
      pop_i = 1'b1; step(); idle();

      // Asynchronous reset mid-cycle with two entries queued
      i = mk(32'h600, 64'h1, 1'b0); step();
      i = mk(32'h604, 64'h2, 1'b0); step();
      idle();
      #2 rst_i = 1'b1;
      #1;
      chk("arst_count", 160'(count_o), 160'(0));
      chk("arst_empty", 160'(empty_o), 160'(1));
      chk("arst_v", 160'(o.v), 160'(0));
      q.delete();
      rst_i = 1'b0;
      pop_i = 1'b1; step(); step();
      idle();

      // Randomized traffic against the reference queue, upstream holds unaccepted pushes
      last_push = 1'b0;
      for (int k = 0; k < 300; k++) begin
         if (!(i.v && !last_push)) begin
            if ($urandom_range(0, 3) != 0)
               i = mk($urandom(), {$urandom(), $urandom()}, 1'($urandom_range(0, 1)));
            else
               i = '0;
         end
         pop_i = ($urandom_range(0, 2) != 0);
         flush_i = ($urandom_range(0, 15) == 0);
         step();
      end
      idle(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/any1_iqueue.md
Name: any1_iqueue

Overview:
- Small instruction queue directly downstream of the instruction aligner; buffers aligned instructions in front of decode.
- Each entry holds the aligned-instruction record from any1_pkg: valid, predict_taken, ir, ip, pip.
- Decouples fetch/align from decode stalls. Provides backpressure upstream and a single-cycle flush for branch redirects and exceptions.

Parameters:
- DEPTH, 4, number of entries; must be a power of 2, at least 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- rst_i  in  1  asynchronous active-high reset
- clk_i  in  1  clock
- flush_i  in  1  discard all entries and any same-cycle push
- i  in  sInstAlignOut  aligned instruction from aligner; i.v qualifies a push
- rdy_o  out  1  queue can accept a push this cycle
- pop_i  in  1  decode consumes head entry
- o  out  sInstAlignOut  head entry; o.v=1 only when queue non-empty
- count_o  out  AW+1  number of valid entries
- full_o  out  1  count_o==DEPTH
- empty_o  out  1  count_o==0

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: rd/wr pointers=0, count_o=0, empty_o=1, full_o=0, o.v=0, rdy_o=1. Storage contents are don't-care, but o.ir, o.ip, o.pip and o.predict_taken read 0 while empty.
- Storage: circular buffer of DEPTH entries with wr_ptr and rd_ptr (AW bits each). Both wrap modulo DEPTH.
- Readiness: rdy_o = !full_o | pop_i. A pop and a push in the same cycle are allowed when full.
- Push accepted: push = i.v & rdy_o & !flush_i. The entry is written at wr_ptr and wr_ptr increments.
- Pop accepted: pop = pop_i & !empty_o & !flush_i. rd_ptr increments. pop_i while empty is ignored with no pointer change.
- Count update (not flushing):
  - push only: count+1
  - pop only: count-1
  - both: unchanged
  - neither: unchanged
- Latency: an entry pushed in cycle N appears on o in cycle N+1 if the queue was empty. No combinational path from i to o.
- Head output: o is read combinationally from storage[rd_ptr], gated by !empty_o.
- Flush: on a rising edge with flush_i=1, pointers and count go to 0. The same-cycle push and pop are both discarded. The queue is empty from the next cycle on.
- Faulted instructions: entries carrying an alignment-fault ir (FLT_IADR pattern) are queued and passed through unchanged. The queue does not inspect ir.
- Reset during operation: all pointers and the count clear immediately. Any in-flight push is lost.
- Upstream contract: when rdy_o=0, the upstream holds i stable until it is accepted.
- Invariant: count_o never exceeds DEPTH and never underflows. Assertion: push with full and no pop must not occur.

Decomposition:
- any1_pkg holds:
  - sInstAlignOut (shared with the aligner)
  - IQ_DEPTH default constant
  - FLT_IADR
- One natural sub-module, any1_iqueue_mem: DEPTH x $bits(sInstAlignOut) register file with one synchronous write port and one asynchronous read port.
- Pointer, count and flush control stay in any1_iqueue.

Test Plan:
- Reset, then push ip=0x100, 0x104, 0x108 in consecutive cycles with no pop -> count_o=3. o.ip=0x100 one cycle after the first push. empty_o=0.
- Fill to DEPTH=4 (ip 0x200..0x20C), hold i.v=1 with ip=0x210 and pop_i=0 -> full_o=1, rdy_o=0, count_o stays 4. Then pop_i=1 -> 0x210 accepted that cycle, count_o stays 4, o.ip becomes 0x204.
- Push and pop continuously for 10 cycles starting at ip=0x300, step 4 -> pointers wrap. Pop order is 0x300, 0x304, ... with no loss or duplication.
- With 3 entries queued, assert flush_i together with i.v=1 (ip=0x400) and pop_i=1 -> next cycle count_o=0, o.v=0, 0x400 not stored.
- Push an entry with ir={40'h0,FLT_IADR,16'h0}, predict_taken=1, ip=0x502 -> the same ir, predict_taken=1 and ip=0x502 appear unmodified at o.
- Assert rst_i asynchronously mid-cycle with 2 entries queued -> count_o=0, empty_o=1 and o.v=0 before the next clk_i edge. pop_i on the empty queue has no effect.
